// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, signed (div) or unsigned (divu), one quotient bit per cycle.
// Latency: out_valid rises WIDTH+2 edges after acceptance, counting the acceptance edge. A zero divisor with FAST_DZ=1 takes 1 edge.
// Backpressure: the result is held in DONE until out_ready. in_ready is high only in IDLE. cancel drops any in-flight or pending result.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake; in_signed, in_dividend, in_divisor are sampled at acceptance
//   cancel                        flush: return to IDLE and discard the result
//   out_valid/out_ready           result handshake; out_quot, out_rem are stable while out_valid is high
//   busy                          high whenever the core is not IDLE
module iter_divider #(
  parameter int WIDTH   = 32,
  parameter bit FAST_DZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // dividend bits shift out at the top; quotient bits shift in at the bottom
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  // Operand preparation at acceptance
  logic             div_zero;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  assign div_zero = (in_divisor == '0);
  assign dvd_neg  = in_signed & in_dividend[WIDTH-1];
  assign dsr_neg  = in_signed & in_divisor[WIDTH-1];
  // The magnitude of MIN is MIN read as unsigned, which is the correct value.
  assign dvd_mag  = dvd_neg ? -in_dividend : in_dividend;
  assign dsr_mag  = dsr_neg ? -in_divisor  : in_divisor;

  // One restoring step
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] diff;

  assign trial = {rem, dvd[WIDTH-1]};
  assign qbit  = (trial >= {1'b0, dsr});
  // When qbit is set the difference is below the divisor, so WIDTH bits hold it exactly.
  assign diff  = trial[WIDTH-1:0] - dsr;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
    end else if (cancel) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt <= CW'(WIDTH - 1);
            rem <= '0;
            if (div_zero) begin
              // Run the raw dividend bits through an unsigned pass with no sign fix.
              // Every trial is >= 0, so the quotient comes out all ones and the
              // remainder ends up equal to the original dividend.
              dvd   <= in_dividend;
              dsr   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              dvd   <= dvd_mag;
              dsr   <= dsr_mag;
              neg_q <= dvd_neg ^ dsr_neg;
              neg_r <= dvd_neg;
            end
            if (div_zero && FAST_DZ) begin
              out_quot  <= '1;
              out_rem   <= in_dividend;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd <= {dvd[WIDTH-2:0], qbit};
          rem <= qbit ? diff : trial[WIDTH-1:0];
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          out_quot  <= neg_q ? -dvd : dvd;
          out_rem   <= neg_r ? -rem : rem;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
